// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the serial multi-nibble adder.
interface serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Multi-nibble add/subtract sequencer: one shared 4-bit adder processes one
// slice per cycle, least significant nibble first, carry kept in a register.
module adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = 5'(i_a) + 5'(i_b) + 5'(i_cin);
endmodule

module serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [KW-1:0]  r_k;
  logic           r_c;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic           r_ovf;
  logic           r_busy;
  logic           r_done;

  logic           w_accept;
  logic           w_last;
  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic [3:0]     w_a_nib;
  logic [3:0]     w_b_nib;
  logic [3:0]     w_nib_sum;
  logic           w_nib_cout;
  logic [W-1:0]   w_res_nxt;
  logic           w_ovf;

  adder_4bit u_adder (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_c),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers see pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. DONE accepts a new start exactly like IDLE.
  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_k == LAST_K);
    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_accept    = bus.start;
        w_state_nxt = bus.start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode, looked ahead one state so busy/done leave from flops.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Slice select and result merge for the nibble currently in flight.
  always_comb begin
    w_a_nib   = r_a[int'(r_k) * 4 +: 4];
    w_b_nib   = r_b[int'(r_k) * 4 +: 4];
    w_res_nxt = r_res;
    w_res_nxt[int'(r_k) * 4 +: 4] = w_nib_sum;
    w_ovf     = (r_a[W-1] == r_b[W-1]) && (w_nib_sum[3] != r_a[W-1]);
  end

  // NOTE: every datapath register, including the operand and partial-result
  // stores, is cleared by reset so an aborted operation leaves no stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_c    <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_a <= bus.a;
        r_b <= bus.sub ? ~bus.b : bus.b;
        r_c <= bus.sub | bus.cin;
        r_k <= '0;
      end else if (r_state == S_RUN) begin
        r_res <= w_res_nxt;
        r_c   <= w_nib_cout;
        if (w_last) begin
          r_sum  <= w_res_nxt;
          r_cout <= w_nib_cout;
          r_ovf  <= w_ovf;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed checks of serial_adder_ctrl (4- and 2-nibble builds)
// against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int N4 = 4;
  localparam int N2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.NIBBLES(N4)) bus4 ();
  serial_adder_ctrl_if #(.NIBBLES(N2)) bus2 ();

  serial_adder_ctrl #(.NIBBLES(N4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  serial_adder_ctrl #(.NIBBLES(N2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } obs_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, input bit cin,
                       output logic [31:0] s, output bit co, output bit ov);
    longint unsigned mask, ua, ub, full;
    longint sa, sb, st, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    if (sub) begin
      s  = 32'((ua - ub) & mask);
      co = (ua >= ub);
      st = sa - sb;
    end else begin
      full = ua + ub + 64'(cin);
      s  = 32'(full & mask);
      co = full[w];
      st = sa + sb + longint'(cin);
    end
    ov = (st > smax) || (st < smin);
  endtask

  task automatic drive(input bit sel, input bit st, input bit sub, input bit cin,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus2.start = st; bus2.sub = sub; bus2.cin = cin; bus2.a = a[7:0]; bus2.b = b[7:0];
    end else begin
      bus4.start = st; bus4.sub = sub; bus4.cin = cin; bus4.a = a[15:0]; bus4.b = b[15:0];
    end
  endtask

  function automatic obs_t observe(input bit sel);
    obs_t o;
    if (sel) begin
      o.busy = bus2.busy; o.done = bus2.done; o.cout = bus2.cout; o.ovf = bus2.ovf;
      o.sum  = 32'(bus2.sum);
    end else begin
      o.busy = bus4.busy; o.done = bus4.done; o.cout = bus4.cout; o.ovf = bus4.ovf;
      o.sum  = 32'(bus4.sum);
    end
    return o;
  endfunction

  // One full operation: start for one edge, wait for done, check everything.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input bit cin, input string tag);
    int n, lat, busy_cnt;
    logic [31:0] es;
    bit eco, eov;
    obs_t o;
    n = sel ? N2 : N4;
    model(4 * n, a, b, sub, cin, es, eco, eov);
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    drive(sel, 1'b1, sub, cin, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, sub, cin, a, b);
    o = observe(sel);
    while (!o.done && lat < 40) begin
      if (o.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      o = observe(sel);
    end
    check({tag, ":latency"}, 64'(lat), 64'(n));
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(n));
    check({tag, ":sum"}, 64'(o.sum), 64'(es));
    check({tag, ":cout"}, 64'(o.cout), 64'(eco));
    check({tag, ":ovf"}, 64'(o.ovf), 64'(eov));
    check({tag, ":busy_at_done"}, 64'(o.busy), 64'd0);
    @(posedge clk); #1;
    o = observe(sel);
    check({tag, ":done_pulse"}, 64'(o.done), 64'd0);
  endtask

  initial begin
    obs_t o;
    logic [31:0] es, es2;
    bit eco, eov;
    int ndone, first_at, second_at;
    logic [31:0] first_sum, second_sum;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = observe(s[0]);
      check("reset:sum", 64'(o.sum), 64'd0);
      check("reset:flags", 64'({o.busy, o.done, o.cout, o.ovf}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    run_op(1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0, "add_basic");
    run_op(1'b0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, "add_wrap");
    run_op(1'b0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, "add_ovf");
    run_op(1'b0, 32'h00FF, 32'h0000, 1'b0, 1'b1, "add_cin");
    run_op(1'b0, 32'h0005, 32'h0007, 1'b1, 1'b1, "sub_neg");
    run_op(1'b0, 32'h8000, 32'h0001, 1'b1, 1'b0, "sub_ovf");
    run_op(1'b0, 32'h1234, 32'h0000, 1'b1, 1'b0, "sub_zero");
    run_op(1'b0, 32'h0000, 32'h8000, 1'b1, 1'b0, "sub_minneg");
    run_op(1'b1, 32'h00F0, 32'h0010, 1'b0, 1'b0, "n2_wrap");

    // Randomized operations on both widths.
    for (int i = 0; i < 30; i++)
      run_op(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand4");
    for (int i = 0; i < 15; i++)
      run_op(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand2");

    // start pulses during RUN must be ignored.
    model(16, 32'h1111, 32'h2222, 1'b0, 1'b0, es, eco, eov);
    ndone = 0; first_at = -1; first_sum = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h2222);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0)      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA, 32'h5555);
      else if (i == 1) drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0F0F, 32'h7777);
      else             drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      o = observe(1'b0);
      if (o.done) begin
        ndone++;
        if (first_at < 0) begin first_at = i; first_sum = o.sum; end
      end
    end
    check("ignore_run:done_count", 64'(ndone), 64'd1);
    check("ignore_run:done_at", 64'(first_at), 64'(N4));
    check("ignore_run:sum", 64'(first_sum), 64'(es));

    // Back-to-back: start held high, new operands offered in the DONE cycle.
    model(16, 32'h1234, 32'h4321, 1'b0, 1'b0, es, eco, eov);
    model(16, 32'h9000, 32'h0001, 1'b1, 1'b0, es2, eco, eov);
    ndone = 0; first_at = -1; second_at = -1; first_sum = '0; second_sum = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h4321);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      o = observe(1'b0);
      if (i == first_at + 1 && first_at >= 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b:busy_after_accept", 64'(o.busy), 64'd1);
      end
      if (o.done) begin
        ndone++;
        if (first_at < 0) begin
          first_at = i; first_sum = o.sum;
          drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h9000, 32'h0001);
        end else if (second_at < 0) begin
          second_at = i; second_sum = o.sum;
        end
      end
    end
    check("b2b:done_count", 64'(ndone), 64'd2);
    check("b2b:first_sum", 64'(first_sum), 64'(es));
    check("b2b:second_sum", 64'(second_sum), 64'(es2));
    check("b2b:spacing", 64'(second_at - first_at), 64'(N4 + 1));

    // Reset asserted in the middle of RUN.
    run_op(1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0F0F, 32'h0101);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    o = observe(1'b0);
    check("midrst:sum", 64'(o.sum), 64'd0);
    check("midrst:flags", 64'({o.busy, o.done, o.cout, o.ovf}), 64'd0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (observe(1'b0).done) ndone++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      o = observe(1'b0);
      if (o.done) ndone++;
    end
    check("midrst:no_done", 64'(ndone), 64'd0);
    check("midrst:sum_after", 64'(o.sum), 64'd0);
    run_op(1'b0, 32'h0F0F, 32'h0101, 1'b0, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
